systolic_os_stream: RTL and testbench

- Output-stationary N1 x N2 multiply-accumulate array that computes one C tile, C[i][j] = sum over k of A[i][k]*B[k][j].
- Next generation of the fixed-size systolic core: reduction length is set at run time, input skew is generated internally, and input and output use valid/ready streams.
- Optional signed saturating accumulation and a drain path with backpressure.
- Sits between the tile fetch logic (A/B BRAM readers) and the C writeback.

---
 rtl/systolic_os_stream_if.sv | 39 +++
 rtl/systolic_os_stream.sv | 235 +++++++++++++++++++++++
 tb/tb_systolic_os_stream.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/systolic_os_stream_if.sv
// Job-control and A/B/C stream bundle for the output-stationary MAC array.
// master = fetch/writeback side, slave = the array itself.
interface systolic_os_stream_if #(
    parameter int D_W     = 8,
    parameter int D_W_ACC = 16,
    parameter int N1      = 4,
    parameter int N2      = 4,
    parameter int K_MAX   = 64
);
    localparam int KW = $clog2(K_MAX + 1);
    localparam int RW = (N1 > 1) ? $clog2(N1) : 1;

    logic                  start;
    logic [KW-1:0]         k_len;
    logic                  busy;
    logic                  in_valid;
    logic                  in_ready;
    logic [N1*D_W-1:0]     a_in;
    logic [N2*D_W-1:0]     b_in;
    logic                  out_valid;
    logic                  out_ready;
    logic [RW-1:0]         out_row;
    logic [N2*D_W_ACC-1:0] out_data;
    logic                  out_last;
    logic                  done;
    logic                  sat_flag;

    modport master (
        output start, k_len, in_valid, a_in, b_in, out_ready,
        input  busy, in_ready, out_valid, out_row, out_data,
        input  out_last, done, sat_flag
    );

    modport slave (
        input  start, k_len, in_valid, a_in, b_in, out_ready,
        output busy, in_ready, out_valid, out_row, out_data,
        output out_last, done, sat_flag
    );
endinterface

// File: rtl/systolic_os_stream.sv
// Output-stationary N1 x N2 MAC array with run-time K, internal input skew,
// valid/ready streams in and out, optional signed saturating accumulation.
module systolic_os_stream #(
    parameter int D_W     = 8,
    parameter int D_W_ACC = 16,
    parameter int N1      = 4,
    parameter int N2      = 4,
    parameter int K_MAX   = 64,
    parameter bit SIGNED  = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    systolic_os_stream_if.slave io
);
    localparam int KW = $clog2(K_MAX + 1);
    localparam int RW = (N1 > 1) ? $clog2(N1) : 1;
    localparam int FL = N1 + N2 - 1;
    localparam int CW = $clog2(K_MAX + FL + N1 + 1);
    localparam int AW = D_W + 1;

    typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DRAIN} state_t;

    state_t        state_q, state_d;
    logic [KW-1:0] klen_q, klen_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          done_q, done_d;
    logic          sat_q, sat_d;

    logic beat_acc;
    logic row_hs;
    logic last_hs;
    logic job_ok;
    logic clr_acc;

    logic [N1*AW-1:0] a_sk;
    logic [N2*AW-1:0] b_sk;

    logic [D_W-1:0]     a_q   [N1][N2];
    logic [D_W-1:0]     b_q   [N1][N2];
    logic               av_q  [N1][N2];
    logic               bv_q  [N1][N2];
    logic [AW-1:0]      a_src [N1][N2];
    logic [AW-1:0]      b_src [N1][N2];
    logic [D_W_ACC-1:0] acc_q [N1][N2];
    logic [D_W_ACC-1:0] acc_d [N1][N2];
    logic [N1*N2-1:0]   sat_pe;

    assign io.busy     = (state_q != IDLE);
    assign io.in_ready = (state_q == LOAD);
    assign io.out_valid = (state_q == DRAIN);
    assign io.out_row  = io.out_valid ? cnt_q[RW-1:0] : '0;
    assign io.out_last = io.out_valid && (cnt_q == CW'(N1 - 1));
    assign io.done     = done_q;
    assign io.sat_flag = sat_q;

    assign beat_acc = io.in_valid && io.in_ready;
    assign row_hs   = io.out_valid && io.out_ready;
    assign last_hs  = row_hs && io.out_last;
    assign job_ok   = (io.k_len != '0) && (io.k_len <= KW'(K_MAX));

    always_comb begin
        io.out_data = '0;
        for (int j = 0; j < N2; j++)
            io.out_data[j*D_W_ACC +: D_W_ACC] = acc_q[cnt_q[RW-1:0]][j];
    end

    always_comb begin
        state_d = state_q;
        klen_d  = klen_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        sat_d   = sat_q | (|sat_pe);
        clr_acc = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (io.start && job_ok) begin
                    state_d = LOAD;
                    klen_d  = io.k_len;
                    cnt_d   = '0;
                    sat_d   = 1'b0;
                end
            end
            LOAD: begin
                if (beat_acc) begin
                    if (cnt_q == CW'(klen_q - 1'b1)) begin
                        state_d = FLUSH;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            FLUSH: begin
                if (cnt_q == CW'(FL - 1)) begin
                    state_d = DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DRAIN: begin
                if (last_hs) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    clr_acc = 1'b1;
                end else if (row_hs) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            klen_q  <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            klen_q  <= klen_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            sat_q   <= sat_d;
        end
    end

    // Lane i/j waits i/j cycles; the PE input register is the last stage.
    for (genvar i = 0; i < N1; i++) begin : g_ask
        logic [AW-1:0] a_new;
        assign a_new = {beat_acc, io.a_in[i*D_W +: D_W]};
        if (i == 0) begin : g_d0
            assign a_sk[0 +: AW] = a_new;
        end else begin : g_dn
            logic [AW-1:0] sr_q [i];
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int d = 0; d < i; d++) sr_q[d] <= '0;
                end else begin
                    sr_q[0] <= a_new;
                    for (int d = 1; d < i; d++) sr_q[d] <= sr_q[d-1];
                end
            end
            assign a_sk[i*AW +: AW] = sr_q[i-1];
        end
    end

    for (genvar j = 0; j < N2; j++) begin : g_bsk
        logic [AW-1:0] b_new;
        assign b_new = {beat_acc, io.b_in[j*D_W +: D_W]};
        if (j == 0) begin : g_d0
            assign b_sk[0 +: AW] = b_new;
        end else begin : g_dn
            logic [AW-1:0] sr_q [j];
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int d = 0; d < j; d++) sr_q[d] <= '0;
                end else begin
                    sr_q[0] <= b_new;
                    for (int d = 1; d < j; d++) sr_q[d] <= sr_q[d-1];
                end
            end
            assign b_sk[j*AW +: AW] = sr_q[j-1];
        end
    end

    always_comb begin
        for (int i = 0; i < N1; i++) begin
            a_src[i][0] = a_sk[i*AW +: AW];
            for (int j = 1; j < N2; j++)
                a_src[i][j] = {av_q[i][j-1], a_q[i][j-1]};
        end
        for (int j = 0; j < N2; j++) begin
            b_src[0][j] = b_sk[j*AW +: AW];
            for (int i = 1; i < N1; i++)
                b_src[i][j] = {bv_q[i-1][j], b_q[i-1][j]};
        end
    end

    // Returns {new_acc, saturated}.
    function automatic logic [D_W_ACC:0] mac(
        input logic [D_W_ACC-1:0] acc,
        input logic [D_W-1:0]     a,
        input logic [D_W-1:0]     b
    );
        logic signed [2*D_W-1:0] p_s;
        logic [2*D_W-1:0]        p_u;
        logic [D_W_ACC-1:0]      ext;
        logic [D_W_ACC:0]        sum;
        p_s = $signed(a) * $signed(b);
        p_u = a * b;
        if (SIGNED) begin
            ext = D_W_ACC'(p_s);
            sum = {acc[D_W_ACC-1], acc} + {ext[D_W_ACC-1], ext};
            if (sum[D_W_ACC] != sum[D_W_ACC-1])
                return {sum[D_W_ACC], {(D_W_ACC-1){~sum[D_W_ACC]}}, 1'b1};
            return {sum[D_W_ACC-1:0], 1'b0};
        end
        ext = D_W_ACC'(p_u);
        return {acc + ext, 1'b0};
    endfunction

    always_comb begin
        sat_pe = '0;
        for (int i = 0; i < N1; i++) begin
            for (int j = 0; j < N2; j++) begin
                acc_d[i][j] = acc_q[i][j];
                if (av_q[i][j] && bv_q[i][j])
                    {acc_d[i][j], sat_pe[i*N2+j]} =
                        mac(acc_q[i][j], a_q[i][j], b_q[i][j]);
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < N1; i++) begin
            for (int j = 0; j < N2; j++) begin
                if (rst) begin
                    a_q[i][j]   <= '0;
                    b_q[i][j]   <= '0;
                    av_q[i][j]  <= 1'b0;
                    bv_q[i][j]  <= 1'b0;
                    acc_q[i][j] <= '0;
                end else begin
                    {av_q[i][j], a_q[i][j]} <= a_src[i][j];
                    {bv_q[i][j], b_q[i][j]} <= b_src[i][j];
                    acc_q[i][j] <= clr_acc ? '0 : acc_d[i][j];
                end
            end
        end
    end
endmodule

// File: tb/tb_systolic_os_stream.sv
// Randomised and directed bench for systolic_os_stream against a
// sum-of-products reference with stepwise signed clamping.
module tb_systolic_os_stream;
    localparam int D_W     = 8;
    localparam int D_W_ACC = 16;
    localparam int N1      = 4;
    localparam int N2      = 4;
    localparam int K_MAX   = 64;
    localparam int KW      = $clog2(K_MAX + 1);
    localparam int RW      = 2;
    localparam int MAXV    = 2**(D_W_ACC-1) - 1;
    localparam int MINV    = -(2**(D_W_ACC-1));

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    systolic_os_stream_if #(
        .D_W(D_W), .D_W_ACC(D_W_ACC), .N1(N1), .N2(N2), .K_MAX(K_MAX)
    ) io ();

    systolic_os_stream #(
        .D_W(D_W), .D_W_ACC(D_W_ACC), .N1(N1), .N2(N2),
        .K_MAX(K_MAX), .SIGNED(1'b1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .io(io)
    );

    int n_pass  = 0;
    int n_total = 0;

    logic [D_W-1:0] a_m [K_MAX][N1];
    logic [D_W-1:0] b_m [K_MAX][N2];
    int exp_c [N1][N2];
    bit exp_sat;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, expv);
    endtask

    function automatic void ref_model(int kl);
        exp_sat = 1'b0;
        for (int i = 0; i < N1; i++) begin
            for (int j = 0; j < N2; j++) begin
                int acc = 0;
                for (int k = 0; k < kl; k++) begin
                    acc += int'($signed(a_m[k][i])) * int'($signed(b_m[k][j]));
                    if (acc > MAXV) begin acc = MAXV; exp_sat = 1'b1; end
                    if (acc < MINV) begin acc = MINV; exp_sat = 1'b1; end
                end
                exp_c[i][j] = acc;
            end
        end
    endfunction

    task automatic fill_const(logic [D_W-1:0] av, logic [D_W-1:0] bv);
        for (int k = 0; k < K_MAX; k++) begin
            for (int i = 0; i < N1; i++) a_m[k][i] = av;
            for (int j = 0; j < N2; j++) b_m[k][j] = bv;
        end
    endtask

    task automatic fill_random();
        for (int k = 0; k < K_MAX; k++) begin
            for (int i = 0; i < N1; i++) a_m[k][i] = D_W'($urandom);
            for (int j = 0; j < N2; j++) b_m[k][j] = D_W'($urandom);
        end
    endtask

    task automatic drive_beat(int idx, bit garbage);
        for (int i = 0; i < N1; i++)
            io.a_in[i*D_W +: D_W] = garbage ? D_W'($urandom) : a_m[idx][i];
        for (int j = 0; j < N2; j++)
            io.b_in[j*D_W +: D_W] = garbage ? D_W'($urandom) : b_m[idx][j];
    endtask

    // vmode: 0 valid held, 1 toggling, 2 random.
    // rmode: 0 ready held, 1 stall at stall_row, 2 random.
    task automatic run_job(string nm, int kl, int vmode, int rmode,
                           int stall_row, int stall_len, bit drain_start);
        int beats = 0;
        int rows = 0;
        int c = 0;
        int stalled = 0;
        bit held = 1'b0;
        bit poked = 1'b0;
        bit got_done = 1'b0;
        bit v;
        logic [RW-1:0] h_row = '0;
        logic [N2*D_W_ACC-1:0] h_data = '0;
        logic [D_W_ACC-1:0] ev;
        ref_model(kl);
        io.start = 1'b1;
        io.k_len = KW'(kl);
        @(posedge clk); #1;
        c = 1;
        io.start = 1'b0;
        while (c < 3000 && !got_done) begin
            if (io.done) begin
                got_done = 1'b1;
                chk({nm, " rows"}, 64'(rows), 64'(N1));
                chk({nm, " busy@done"}, 64'(io.busy), 64'(0));
                chk({nm, " ovalid@done"}, 64'(io.out_valid), 64'(0));
                chk({nm, " sat"}, 64'(io.sat_flag), 64'(exp_sat));
                if (vmode == 0 && rmode == 0)
                    chk({nm, " latency"}, 64'(c),
                        64'(1 + kl + (N1 + N2 - 1) + N1));
            end else begin
                chk({nm, " in_ready"}, 64'(io.in_ready), 64'(beats < kl));
                chk({nm, " busy"}, 64'(io.busy), 64'(1));
                case (vmode)
                    0: v = 1'b1;
                    1: v = (c % 2 == 1);
                    default: v = 1'(($urandom_range(0, 1)));
                endcase
                io.in_valid = v;
                drive_beat(beats, beats >= kl);
                if (v && beats < kl) beats++;
                if (held) begin
                    chk({nm, " hold valid"}, 64'(io.out_valid), 64'(1));
                    chk({nm, " hold row"}, 64'(io.out_row), 64'(h_row));
                    chk({nm, " hold data"}, 64'(io.out_data), 64'(h_data));
                    held = 1'b0;
                end
                case (rmode)
                    0: io.out_ready = 1'b1;
                    1: begin
                        io.out_ready = 1'b1;
                        if (io.out_valid && rows == stall_row &&
                            stalled < stall_len) begin
                            io.out_ready = 1'b0;
                            stalled++;
                        end
                    end
                    default: io.out_ready = 1'(($urandom_range(0, 1)));
                endcase
                if (io.out_valid && io.out_ready) begin
                    chk($sformatf("%s row%0d idx", nm, rows),
                        64'(io.out_row), 64'(rows));
                    chk($sformatf("%s row%0d last", nm, rows),
                        64'(io.out_last), 64'(rows == N1 - 1));
                    for (int j = 0; j < N2; j++) begin
                        ev = D_W_ACC'(exp_c[rows % N1][j]);
                        chk($sformatf("%s C[%0d][%0d]", nm, rows, j),
                            64'(io.out_data[j*D_W_ACC +: D_W_ACC]), 64'(ev));
                    end
                    rows++;
                end else if (io.out_valid) begin
                    held = 1'b1;
                    h_row = io.out_row;
                    h_data = io.out_data;
                end
                io.start = 1'b0;
                if (drain_start && io.out_valid && !poked) begin
                    io.start = 1'b1;
                    io.k_len = KW'(3);
                    poked = 1'b1;
                end
                @(posedge clk); #1;
                c++;
            end
        end
        if (!got_done) chk({nm, " timeout"}, 64'(0), 64'(1));
        io.start = 1'b0;
        io.in_valid = 1'b0;
        io.out_ready = 1'b1;
        @(posedge clk); #1;
        chk({nm, " idle after"}, 64'(io.busy), 64'(0));
        chk({nm, " done pulse"}, 64'(io.done), 64'(0));
    endtask

    initial begin
        rst = 1'b1;
        io.start = 1'b0;
        io.k_len = '0;
        io.in_valid = 1'b0;
        io.a_in = '0;
        io.b_in = '0;
        io.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst busy", 64'(io.busy), 64'(0));
        chk("rst in_ready", 64'(io.in_ready), 64'(0));
        chk("rst out_valid", 64'(io.out_valid), 64'(0));
        chk("rst out_last", 64'(io.out_last), 64'(0));
        chk("rst done", 64'(io.done), 64'(0));
        chk("rst sat", 64'(io.sat_flag), 64'(0));
        chk("rst out_row", 64'(io.out_row), 64'(0));
        rst = 1'b0;
        @(posedge clk); #1;

        fill_const('0, '0);
        for (int k = 0; k < N1; k++) begin
            for (int i = 0; i < N1; i++) a_m[k][i] = (i == k) ? 8'd1 : 8'd0;
            for (int j = 0; j < N2; j++) b_m[k][j] = D_W'(4 * k + j + 1);
        end
        run_job("ident", 4, 0, 0, 0, 0, 1'b0);
        run_job("toggle", 4, 1, 0, 0, 0, 1'b0);
        run_job("stall", 4, 0, 1, 1, 5, 1'b0);

        fill_const(8'h80, 8'h80);
        run_job("satneg", 3, 0, 0, 0, 0, 1'b0);
        fill_const(8'd1, 8'd1);
        run_job("satclr", 3, 0, 0, 0, 0, 1'b0);
        run_job("k1", 1, 0, 0, 0, 0, 1'b0);
        run_job("k64", K_MAX, 0, 0, 0, 0, 1'b0);

        io.start = 1'b1;
        io.k_len = KW'(0);
        @(posedge clk); #1;
        chk("klen0 busy", 64'(io.busy), 64'(0));
        io.k_len = KW'(K_MAX + 1);
        @(posedge clk); #1;
        chk("klen65 busy", 64'(io.busy), 64'(0));
        io.start = 1'b0;
        @(posedge clk); #1;
        chk("klen65 idle", 64'(io.busy), 64'(0));

        fill_random();
        io.start = 1'b1;
        io.k_len = KW'(5);
        @(posedge clk); #1;
        io.start = 1'b0;
        io.in_valid = 1'b1;
        drive_beat(0, 1'b0);
        @(posedge clk); #1;
        drive_beat(1, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort busy", 64'(io.busy), 64'(0));
        chk("abort in_ready", 64'(io.in_ready), 64'(0));
        chk("abort out_valid", 64'(io.out_valid), 64'(0));
        rst = 1'b0;
        io.in_valid = 1'b0;
        @(posedge clk); #1;
        fill_random();
        run_job("post_abort", 2, 0, 0, 0, 0, 1'b1);

        for (int r = 0; r < 4; r++) begin
            fill_random();
            run_job($sformatf("rand%0d", r), int'($urandom_range(1, K_MAX)),
                    2, 2, 0, 0, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
